// File: rtl/kuramoto_order_parameter.sv
// Kuramoto order parameter for six oscillators in Cartesian form.
// Each oscillator is normalised to a unit vector, the six unit vectors are
// summed, and the magnitude (scaled by 1/6) and phase of the sum are
// registered on clk edges where clk_en is high.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   clk_en          capture strobe; outputs hold while low
//   <osc>_x/<osc>_y signed WIDTH Q.FRAC oscillator states
//                   (theta, alpha, beta1, beta2, gamma, sr_f0)
//   kuramoto_R      order parameter R, 0..2^FRAC
//   mean_phase      phase of the mean vector, -pi..+pi in Q.FRAC radians
//   high_synchrony  R strictly above 0.7
module kuramoto_order_parameter #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned FRAC  = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] theta_x,
  input  logic signed [WIDTH-1:0] theta_y,
  input  logic signed [WIDTH-1:0] alpha_x,
  input  logic signed [WIDTH-1:0] alpha_y,
  input  logic signed [WIDTH-1:0] beta1_x,
  input  logic signed [WIDTH-1:0] beta1_y,
  input  logic signed [WIDTH-1:0] beta2_x,
  input  logic signed [WIDTH-1:0] beta2_y,
  input  logic signed [WIDTH-1:0] gamma_x,
  input  logic signed [WIDTH-1:0] gamma_y,
  input  logic signed [WIDTH-1:0] sr_f0_x,
  input  logic signed [WIDTH-1:0] sr_f0_y,
  output logic signed [WIDTH-1:0] kuramoto_R,
  output logic signed [WIDTH-1:0] mean_phase,
  output logic                    high_synchrony
);

  localparam int unsigned N     = 6;
  localparam int unsigned SW    = WIDTH + 4;      // unit-vector sum width
  localparam int unsigned MW    = SW + 1;         // alpha-max-beta-min result width
  localparam int unsigned NW    = WIDTH + FRAC + 1; // normalisation numerator width
  localparam int unsigned UW    = FRAC + 3;       // unit-vector component width
  localparam int unsigned RW    = MW + 12;        // R product width (2731 < 2^12)
  localparam int unsigned PW    = MW + FRAC;      // phase ratio numerator width
  localparam int unsigned AW    = FRAC + 4;       // angle width, holds +/-pi
  localparam int unsigned UNITY = 1 << FRAC;
  localparam int unsigned DIV6  = 2731;           // 2^14 / 6, applied with >> 14
  localparam int unsigned PI_Q  = $rtoi(3.14159265358979 * (2.0 ** FRAC) + 0.5);
  localparam int unsigned PI2_Q = $rtoi(1.57079632679490 * (2.0 ** FRAC) + 0.5);
  localparam int unsigned PI4_Q = $rtoi(0.78539816339745 * (2.0 ** FRAC) + 0.5);
  localparam int unsigned THR_Q = $rtoi(0.7 * (2.0 ** FRAC) + 0.5);

  // Absolute value of an input; the most-negative code saturates to max positive.
  function automatic logic [WIDTH-1:0] abs_in(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] res;
    if (v[WIDTH-1]) begin
      if (v == $signed({1'b1, {(WIDTH-1){1'b0}}})) begin
        res = {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        res = WIDTH'(-v);
      end
    end else begin
      res = WIDTH'(v);
    end
    return res;
  endfunction

  // Absolute value of a sum, same saturating behaviour at the sum width.
  function automatic logic [SW-1:0] abs_sum(input logic signed [SW-1:0] v);
    logic [SW-1:0] res;
    if (v[SW-1]) begin
      if (v == $signed({1'b1, {(SW-1){1'b0}}})) begin
        res = {1'b0, {(SW-1){1'b1}}};
      end else begin
        res = SW'(-v);
      end
    end else begin
      res = SW'(v);
    end
    return res;
  endfunction

  // Alpha-max-beta-min magnitude estimate, beta = 1/4 + 1/8.
  function automatic logic [MW-1:0] amax_bmin(input logic [SW-1:0] a,
                                              input logic [SW-1:0] b);
    logic [SW-1:0] mx;
    logic [SW-1:0] mn;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return MW'(mx) + MW'(mn >> 2) + MW'(mn >> 3);
  endfunction

  // (v << FRAC) / m, signed, truncating toward zero.
  function automatic logic signed [NW-1:0] scale_div(input logic signed [WIDTH-1:0] v,
                                                     input logic [MW-1:0] m);
    logic signed [NW-1:0] num;
    logic signed [NW-1:0] den;
    num = NW'(v) <<< FRAC;
    den = $signed(NW'(m));
    return num / den;
  endfunction

  // Gather oscillator states so the normalisation can be written as one loop.
  logic signed [WIDTH-1:0] osc_x [N];
  logic signed [WIDTH-1:0] osc_y [N];

  assign osc_x[0] = theta_x;
  assign osc_y[0] = theta_y;
  assign osc_x[1] = alpha_x;
  assign osc_y[1] = alpha_y;
  assign osc_x[2] = beta1_x;
  assign osc_y[2] = beta1_y;
  assign osc_x[3] = beta2_x;
  assign osc_y[3] = beta2_y;
  assign osc_x[4] = gamma_x;
  assign osc_y[4] = gamma_y;
  assign osc_x[5] = sr_f0_x;
  assign osc_y[5] = sr_f0_y;

  // Normalise every oscillator to a unit vector and accumulate.
  logic signed [SW-1:0] sum_x;
  logic signed [SW-1:0] sum_y;

  always_comb begin : unit_sum
    logic [MW-1:0]        mag;
    logic signed [UW-1:0] ux;
    logic signed [UW-1:0] uy;
    sum_x = '0;
    sum_y = '0;
    mag   = '0;
    ux    = '0;
    uy    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mag = amax_bmin(SW'(abs_in(osc_x[i])), SW'(abs_in(osc_y[i])));
      if (mag == '0) begin
        ux = '0;
        uy = '0;
      end else begin
        ux = UW'(scale_div(osc_x[i], mag));
        uy = UW'(scale_div(osc_y[i], mag));
      end
      sum_x = sum_x + SW'(ux);
      sum_y = sum_y + SW'(uy);
    end
  end

  // Order parameter: |sum| / 6, clamped to unity, plus the synchrony flag.
  logic [MW-1:0]           rsum;
  logic [RW-1:0]           r_prod;
  logic [RW-1:0]           r_scaled;
  logic signed [WIDTH-1:0] r_c;
  logic                    hs_c;

  always_comb begin : order_mag
    rsum     = amax_bmin(abs_sum(sum_x), abs_sum(sum_y));
    r_prod   = RW'(rsum) * RW'(DIV6);
    r_scaled = r_prod >> 14;
    if (r_scaled > RW'(UNITY)) begin
      r_c = $signed(WIDTH'(UNITY));
    end else begin
      r_c = $signed(WIDTH'(r_scaled));
    end
    hs_c = (r_c > $signed(WIDTH'(THR_Q)));
  end

  // Mean phase: first-octant linear atan, then reflected into the full circle.
  logic [SW-1:0]           ph_ax;
  logic [SW-1:0]           ph_ay;
  logic [SW-1:0]           ph_max;
  logic [SW-1:0]           ph_min;
  logic [PW-1:0]           ph_ratio;
  logic signed [AW-1:0]    ph_base;
  logic signed [AW-1:0]    ph_ang;
  logic signed [WIDTH-1:0] phase_c;

  always_comb begin : order_phase
    ph_ax    = abs_sum(sum_x);
    ph_ay    = abs_sum(sum_y);
    ph_max   = (ph_ax > ph_ay) ? ph_ax : ph_ay;
    ph_min   = (ph_ax > ph_ay) ? ph_ay : ph_ax;
    ph_ratio = '0;
    ph_base  = '0;
    ph_ang   = '0;
    if (ph_max != '0) begin
      ph_ratio = (PW'(ph_min) << FRAC) / PW'(ph_max);
      ph_base  = $signed(AW'((ph_ratio * PW'(PI4_Q)) >> FRAC));
      // Steep vectors measure the angle from the y axis.
      if (ph_ay <= ph_ax) begin
        ph_ang = ph_base;
      end else begin
        ph_ang = $signed(AW'(PI2_Q)) - ph_base;
      end
      if (sum_x[SW-1]) begin
        ph_ang = $signed(AW'(PI_Q)) - ph_ang;
      end
      if (sum_y[SW-1]) begin
        ph_ang = -ph_ang;
      end
    end
    phase_c = WIDTH'(ph_ang);
  end

  // Output registers, captured together on enabled edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kuramoto_R     <= '0;
      mean_phase     <= '0;
      high_synchrony <= 1'b0;
    end else if (clk_en) begin
      kuramoto_R     <= r_c;
      mean_phase     <= phase_c;
      high_synchrony <= hs_c;
    end
  end

endmodule

// File: tb/tb_kuramoto_order_parameter.sv
// Self-checking bench for kuramoto_order_parameter: directed and random
// oscillator patterns, expected outputs queued on drive and checked after
// the capturing edge, plus bound checks, hold and asynchronous reset.
module tb_kuramoto_order_parameter;

  localparam int WIDTH = 18;
  localparam int FRAC  = 14;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic clk_en = 1'b0;
  logic signed [WIDTH-1:0] ix [6];
  logic signed [WIDTH-1:0] iy [6];
  logic signed [WIDTH-1:0] kuramoto_R;
  logic signed [WIDTH-1:0] mean_phase;
  logic                    high_synchrony;

  kuramoto_order_parameter #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .theta_x(ix[0]), .theta_y(iy[0]),
    .alpha_x(ix[1]), .alpha_y(iy[1]),
    .beta1_x(ix[2]), .beta1_y(iy[2]),
    .beta2_x(ix[3]), .beta2_y(iy[3]),
    .gamma_x(ix[4]), .gamma_y(iy[4]),
    .sr_f0_x(ix[5]), .sr_f0_y(iy[5]),
    .kuramoto_R(kuramoto_R), .mean_phase(mean_phase),
    .high_synchrony(high_synchrony)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int   r;
    int   ph;
    logic hs;
  } exp_t;

  exp_t  sb [$];
  string sb_tag [$];
  int    tests = 0;
  int    fails = 0;
  int    m_sx, m_sy;
  exp_t  last_e;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic int t_abs(input int v);
    if (v <= -131072) return 131071;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int t_mag(input int a, input int b);
    int mx, mn;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return mx + (mn / 4) + (mn / 8);
  endfunction

  // Reference arithmetic on the currently driven inputs.
  task automatic model(output exp_t e);
    int sx, sy, m, ax, ay, mx, mn, base, ang;
    longint q, ratio;
    sx = 0;
    sy = 0;
    for (int i = 0; i < 6; i++) begin
      m = t_mag(t_abs(int'(ix[i])), t_abs(int'(iy[i])));
      if (m != 0) begin
        sx += int'((longint'(ix[i]) * 16384) / m);
        sy += int'((longint'(iy[i]) * 16384) / m);
      end
    end
    m_sx = sx;
    m_sy = sy;
    q = (longint'(t_mag(t_abs(sx), t_abs(sy))) * 2731) / 16384;
    e.r  = (q > 16384) ? 16384 : int'(q);
    e.hs = (e.r > 11469);
    ax = t_abs(sx);
    ay = t_abs(sy);
    mx = (ax > ay) ? ax : ay;
    mn = (ax > ay) ? ay : ax;
    ang = 0;
    if (mx != 0) begin
      ratio = (longint'(mn) * 16384) / mx;
      base  = int'((ratio * 12868) / 16384);
      ang   = (ay <= ax) ? base : 25736 - base;
      if (sx < 0) ang = 51472 - ang;
      if (sy < 0) ang = -ang;
    end
    e.ph = ang;
  endtask

  task automatic chk(input string tag, input int got, input int exp_v);
    tests++;
    assert (got === exp_v) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp_v);
    end
  endtask

  // Strict open interval lo < got < hi.
  task automatic chk_range(input string tag, input int got, input int lo, input int hi);
    tests++;
    assert (got > lo && got < hi) else begin
      fails++;
      $error("FAIL %s: got %0d expected in (%0d,%0d)", tag, got, lo, hi);
    end
  endtask

  // Phase against a true atan2 of the reference sums, tolerance 0.08 rad.
  task automatic chk_atan(input string tag, input int got);
    real ref_a, d;
    if (m_sx == 0 && m_sy == 0) return;
    ref_a = $atan2(real'(m_sy), real'(m_sx)) * 16384.0;
    d = real'(got) - ref_a;
    if (d > 51471.85) d = d - 102943.7;
    if (d < -51471.85) d = d + 102943.7;
    tests++;
    assert (d <= 1311.0 && d >= -1311.0) else begin
      fails++;
      $error("FAIL %s_atan: got %0d expected %0d +/-1311", tag, got, $rtoi(ref_a));
    end
  endtask

  task automatic set_all(input int x, input int y);
    for (int i = 0; i < 6; i++) begin
      ix[i] = WIDTH'(x);
      iy[i] = WIDTH'(y);
    end
  endtask

  task automatic set_one(input int i, input int x, input int y);
    ix[i] = WIDTH'(x);
    iy[i] = WIDTH'(y);
  endtask

  // One enabled capture: queue the expectation, clock, then check.
  task automatic apply(input string tag);
    exp_t  e;
    string t;
    model(e);
    sb.push_back(e);
    sb_tag.push_back(tag);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    e = sb.pop_front();
    t = sb_tag.pop_front();
    chk({t, "_R"}, int'(kuramoto_R), e.r);
    chk({t, "_phase"}, int'(mean_phase), e.ph);
    chk({t, "_hs"}, int'(high_synchrony), int'(e.hs));
    chk_atan(t, int'(mean_phase));
    last_e = e;
  endtask

  initial begin
    set_all(0, 0);

    // Asynchronous reset with no clock edge.
    #1 rst = 1'b1;
    #2;
    chk("reset_R", int'(kuramoto_R), 0);
    chk("reset_phase", int'(mean_phase), 0);
    chk("reset_hs", int'(high_synchrony), 0);

    // Reset wins over clk_en.
    set_all(16384, 0);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_over_en_R", int'(kuramoto_R), 0);
    chk("rst_over_en_hs", int'(high_synchrony), 0);
    clk_en = 1'b0;
    rst = 1'b0;

    // All in phase at angle 0.
    apply("phase0");
    chk("phase0_R_exact", int'(kuramoto_R), 16384);
    chk("phase0_hs_set", int'(high_synchrony), 1);
    chk_range("phase0_phase_near0", int'(mean_phase), -1312, 1312);

    // All at pi/4.
    set_all(11585, 11585);
    apply("pi4");
    chk_range("pi4_R", int'(kuramoto_R), 14746, 32768);
    chk_range("pi4_phase", int'(mean_phase), 12868 - 1312, 12868 + 1312);

    // Three opposed pairs cancel.
    for (int i = 0; i < 6; i++) set_one(i, (i < 3) ? 16384 : -16384, 0);
    apply("cancel33");
    chk_range("cancel33_R", int'(kuramoto_R), -1, 1638);

    // Six phases evenly spread.
    set_one(0, 16384, 0);
    set_one(1, 8192, 14189);
    set_one(2, -8192, 14189);
    set_one(3, -16384, 0);
    set_one(4, -8192, -14189);
    set_one(5, 8192, -14189);
    apply("spread6");
    chk_range("spread6_R", int'(kuramoto_R), -1, 3277);

    // Four/two and five/one splits.
    for (int i = 0; i < 6; i++) set_one(i, (i < 4) ? 16384 : -16384, 0);
    apply("split42");
    chk_range("split42_R", int'(kuramoto_R), 3277, 8192);
    for (int i = 0; i < 6; i++) set_one(i, (i < 5) ? 16384 : -16384, 0);
    apply("split51");
    chk_range("split51_R", int'(kuramoto_R), 9830, 12288);
    chk("split51_hs_clear", int'(high_synchrony), 0);

    // Amplitude independence.
    set_one(0, 16384, 0);
    set_one(1, 8192, 0);
    set_one(2, 32768, 0);
    set_one(3, 4096, 0);
    set_one(4, 16384, 0);
    set_one(5, 8192, 0);
    apply("amp_mix");
    chk_range("amp_mix_R", int'(kuramoto_R), 14746, 32768);

    // Other octants and the most-negative input code.
    set_all(0, -16384);
    apply("neg_y");
    chk("neg_y_phase_val", int'(mean_phase), -25736);
    set_all(-11585, 11585);
    apply("q2_diag");
    set_all(-131072, 0);
    apply("most_neg");
    chk("most_neg_phase_val", int'(mean_phase), 51472);
    set_all(5000, -9000);
    set_one(2, 0, 0);
    apply("with_zero");

    // Random patterns.
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 6; i++) begin
        set_one(i, int'($urandom_range(0, 80000)) - 40000,
                   int'($urandom_range(0, 80000)) - 40000);
      end
      apply($sformatf("rand%0d", n));
    end

    // Hold while clk_en is low.
    set_all(-3000, 7000);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("hold_R", int'(kuramoto_R), last_e.r);
    chk("hold_phase", int'(mean_phase), last_e.ph);
    chk("hold_hs", int'(high_synchrony), int'(last_e.hs));

    // Reset mid-run, between edges.
    set_all(16384, 0);
    apply("pre_rst");
    #2 rst = 1'b1;
    #1;
    chk("midrst_R", int'(kuramoto_R), 0);
    chk("midrst_phase", int'(mean_phase), 0);
    chk("midrst_hs", int'(high_synchrony), 0);
    #1 rst = 1'b0;
    set_all(0, 16384);
    @(posedge clk);
    #1;
    apply("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kuramoto_order_parameter.md
KURAMOTO_ORDER_PARAMETER -- requirements
Module: kuramoto_order_parameter

Interface
REQ-001 Parameter WIDTH, default 18: bit width of every data port, signed two's complement.
REQ-002 Parameter FRAC, default 14: fractional bits; unity = 2^FRAC (16384).
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 clk_en  input  1  update strobe; outputs change only on a clk edge with clk_en=1.
REQ-007 Oscillator inputs, each input, signed WIDTH, Qx.FRAC Cartesian state: theta_x/theta_y, alpha_x/alpha_y, beta1_x/beta1_y, beta2_x/beta2_y, gamma_x/gamma_y, sr_f0_x/sr_f0_y.
REQ-008 kuramoto_R  output  signed WIDTH  order parameter R in Q.FRAC, range 0..2^FRAC.
REQ-009 mean_phase  output  signed WIDTH  phase of the mean vector, Q.FRAC radians, range -pi..+pi (+/-51472).
REQ-010 high_synchrony  output  1  set when R exceeds 0.7.

Function
REQ-011 Per oscillator i: ax=|x|, ay=|y|; mag_i = max(ax,ay) + (min(ax,ay)>>2) + (min(ax,ay)>>3) (alpha-max-beta-min, beta=3/8).
REQ-012 Unit vector: ux_i = (x_i << FRAC) / mag_i, uy_i = (y_i << FRAC) / mag_i, signed, truncating toward zero; if mag_i = 0 then ux_i = uy_i = 0.
REQ-013 Result is amplitude-independent: any positive scaling of an oscillator (1/4x to 2x of unity, no overflow) leaves its contribution within 1% of unity magnitude.
REQ-014 Sums Sx = sum ux_i, Sy = sum uy_i over all six, computed in at least WIDTH+4 bits with no overflow.
REQ-015 Rsum = same alpha-max-beta-min magnitude of (Sx,Sy); R = (Rsum * 2731) >> 14 (divide by 6); R clamped to 2^FRAC.
REQ-016 mean_phase = atan2(Sy,Sx) by octant reduction: r = (min<<FRAC)/max, base = r*pi/4 (pi/4 = 12868 in Q14), octant-mapped to full circle; absolute error <= 0.08 rad; Sx=Sy=0 -> 0.
REQ-017 high_synchrony = 1 iff computed R > 11469 (0.7 in Q14), strictly greater.
REQ-018 All arithmetic combinational from current inputs; on a rising clk edge with clk_en=1, kuramoto_R, mean_phase and high_synchrony register simultaneously (single-cycle latency, valid after that edge).
REQ-019 clk_en=0: all outputs hold their last values regardless of input changes.
REQ-020 Inputs at most-negative value: absolute value saturates to max positive before magnitude computation.

Reset
REQ-021 rst=1 immediately forces kuramoto_R=0, mean_phase=0, high_synchrony=0, independent of clk.
REQ-022 rst asserted while clk_en=1 wins; first capture after release uses inputs present at that edge.

Verification
REQ-023 All six at (16384,0), one clk_en pulse -> kuramoto_R > 14746 (expect 16384), high_synchrony=1, mean_phase ~0.
REQ-024 All six at (11585,11585) -> kuramoto_R > 14746, mean_phase ~12868 (pi/4) +/-1311.
REQ-025 Three at (16384,0), three at (-16384,0) -> kuramoto_R < 1638, high_synchrony=0; six phases at k*pi/3 ((+/-8192,+/-14189), (+/-16384,0)) -> kuramoto_R < 3277.
REQ-026 Four at (16384,0), two at (-16384,0) -> 3277 < R < 8192; five/one split -> 9830 < R < 12288 (~10923), high_synchrony=0.
REQ-027 All at phase 0 with x amplitudes 16384, 8192, 32768, 4096, 16384, 8192 -> kuramoto_R > 14746.
REQ-028 Change inputs with clk_en=0 -> outputs unchanged; assert rst mid-run -> all outputs 0 without a clock edge.
